// File: rtl/fir_pkg.sv
// Shared types and helpers for the FIR moving-sum stage and its averaging/decimating consumer.
package fir_pkg;

    typedef enum logic {WARM, RUN} warm_t;

    localparam int unsigned FirW      = 16;
    localparam int unsigned FirWarmup = 5;

    // Rounded divide-by-4 of a moving sum; the caller truncates to the sample width.
    function automatic logic [31:0] round_div4(input logic [31:0] sum);
        return (sum + 32'd2) >> 2;
    endfunction

endpackage

// File: rtl/fir_avg_decim_if.sv
// Valid/ready output channel carrying averaged samples toward the next consumer.
interface fir_avg_decim_if #(
    parameter int unsigned w = 16
);
    logic [w-1:0] dout;
    logic         dout_valid;
    logic         dout_ready;

    modport master (output dout, output dout_valid, input dout_ready);
    modport slave  (input dout, input dout_valid, output dout_ready);
endinterface

// File: rtl/fir_sfifo.sv
// Synchronous first-word-fall-through FIFO with wrap-bit pointers; reads 0 when empty.
module fir_sfifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     valid_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int unsigned AddrW = $clog2(DEPTH);
    localparam int unsigned PtrW  = AddrW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PtrW-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic             empty, full, pop, push;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AddrW] != rd_q[AddrW]) && (wr_q[AddrW-1:0] == rd_q[AddrW-1:0]);
    assign pop   = pop_i & ~empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push  = push_i & (~full | pop);

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (push) begin
            mem_d[wr_q[AddrW-1:0]] = data_i;
            wr_d                   = wr_q + 1'b1;
        end
        if (pop) begin
            rd_d = rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign data_o  = empty ? '0 : mem_q[rd_q[AddrW-1:0]];
    assign valid_o = ~empty;
    assign full_o  = full;
    assign level_o = wr_q - rd_q;
endmodule

// File: rtl/fir_avg_decim.sv
// Suppresses FIR pipeline-fill samples, rounds sums to averages, decimates by D and buffers.
module fir_avg_decim
    import fir_pkg::*;
#(
    parameter int unsigned w      = FirW,
    parameter int unsigned D      = 2,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned WARMUP = FirWarmup
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [w+1:0]           s_in,
    fir_avg_decim_if.master        out,
    output logic [$clog2(DEPTH):0] level,
    output logic                   ovf
);
    localparam int unsigned CntW = $clog2(WARMUP + 1) + 1;
    localparam int unsigned DecW = (D > 1) ? $clog2(D) : 1;

    warm_t            state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [DecW-1:0]  dec_q, dec_d;
    logic             ovf_q, ovf_d;
    logic             keep, pop, full;
    logic [w-1:0]     avg;

    assign avg = w'(round_div4(32'(s_in)));
    assign pop = out.dout_valid & out.dout_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dec_d   = dec_q;
        keep    = 1'b0;
        unique case (state_q)
            WARM: begin
                // Saturates at WARMUP so RUN begins exactly WARMUP cycles after release.
                if (cnt_q == CntW'(WARMUP)) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                keep  = (dec_q == '0);
                dec_d = (dec_q == DecW'(D - 1)) ? '0 : dec_q + 1'b1;
            end
            default: state_d = WARM;
        endcase
    end

    assign ovf_d = ovf_q | (keep & full & ~pop);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= WARM;
            cnt_q   <= '0;
            dec_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dec_q   <= dec_d;
            ovf_q   <= ovf_d;
        end
    end

    fir_sfifo #(
        .WIDTH (w),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (reset),
        .push_i  (keep),
        .data_i  (avg),
        .pop_i   (out.dout_ready),
        .data_o  (out.dout),
        .valid_o (out.dout_valid),
        .full_o  (full),
        .level_o (level)
    );

    assign ovf = ovf_q;
endmodule

// File: tb/tb_fir_avg_decim.sv
// Directed bench for fir_avg_decim: warm-up, rounding, backpressure, overflow, reset, D=1/3.
module tb_fir_avg_decim;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [17:0] s_in;
    logic [2:0]  level2, level1, level3;
    logic        ovf2, ovf1, ovf3;

    fir_avg_decim_if #(.w(16)) if2 (), if1 (), if3 ();

    fir_avg_decim #(.w(16), .D(2), .DEPTH(4), .WARMUP(5)) u_d2 (
        .clk(clk), .reset(reset), .s_in(s_in), .out(if2), .level(level2), .ovf(ovf2)
    );
    fir_avg_decim #(.w(16), .D(1), .DEPTH(4), .WARMUP(5)) u_d1 (
        .clk(clk), .reset(reset), .s_in(s_in), .out(if1), .level(level1), .ovf(ovf1)
    );
    fir_avg_decim #(.w(16), .D(3), .DEPTH(4), .WARMUP(5)) u_d3 (
        .clk(clk), .reset(reset), .s_in(s_in), .out(if3), .level(level3), .ovf(ovf3)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s c%0d: observed %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; cyc then names the current cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        reset          = 1'b0;
        s_in           = 18'd100;
        if2.dout_ready = 1'b1;
        if1.dout_ready = 1'b1;
        if3.dout_ready = 1'b1;
        tick();
        chk("rst_level", 32'(level2), 0);
        chk("rst_valid", 32'(if2.dout_valid), 0);
        chk("rst_ovf", 32'(ovf2), 0);
        chk("rst_dout", 32'(if2.dout), 0);

        // Warm-up with constant input.
        reset = 1'b1;
        cyc   = -1;
        tick();
        for (int n = 0; n < 6; n++) begin
            chk("warm_valid", 32'(if2.dout_valid), 0);
            tick();
        end
        chk("first_valid", 32'(if2.dout_valid), 1);
        chk("first_dout", 32'(if2.dout), 25);
        tick();
        chk("gap_valid", 32'(if2.dout_valid), 0);
        tick();
        chk("second_valid", 32'(if2.dout_valid), 1);
        chk("second_dout", 32'(if2.dout), 25);

        // Rounding in kept slots (odd cycles).
        s_in = 18'd0;
        tick(); s_in = 18'd6;
        tick(); chk("round_6", 32'(if2.dout), 2); s_in = 18'd0;
        tick(); s_in = 18'd5;
        tick(); chk("round_5", 32'(if2.dout), 1); s_in = 18'd0;
        tick(); s_in = 18'd262140;
        tick(); chk("round_max", 32'(if2.dout), 65535); s_in = 18'd0;

        // Backpressure: fill with 10, 20, 30, 40.
        tick(); if2.dout_ready = 1'b0; s_in = 18'd40;
        tick(); chk("bp_level1", 32'(level2), 1); s_in = 18'd0;
        tick(); s_in = 18'd80;
        tick(); s_in = 18'd0;
        tick(); s_in = 18'd120;
        tick(); s_in = 18'd0;
        tick(); s_in = 18'd160;
        tick();
        chk("bp_level4", 32'(level2), 4);
        chk("bp_ovf0", 32'(ovf2), 0);
        chk("bp_head", 32'(if2.dout), 10);
        s_in = 18'd0;

        // Full with simultaneous pop and push of 50.
        tick(); if2.dout_ready = 1'b1; s_in = 18'd200;
        chk("pp_head_before", 32'(if2.dout), 10);
        tick();
        chk("pp_level", 32'(level2), 4);
        chk("pp_ovf", 32'(ovf2), 0);
        chk("pp_head_after", 32'(if2.dout), 20);
        if2.dout_ready = 1'b0; s_in = 18'd0;

        // Full, no pop: 60 is dropped.
        tick(); s_in = 18'd240;
        tick();
        chk("ov_ovf", 32'(ovf2), 1);
        chk("ov_level", 32'(level2), 4);
        chk("ov_head", 32'(if2.dout), 20);
        if2.dout_ready = 1'b1; s_in = 18'd0;
        tick();
        chk("ov_order30", 32'(if2.dout), 30);
        chk("ov_level3", 32'(level2), 3);
        s_in = 18'd280;
        tick();
        chk("ov_order40", 32'(if2.dout), 40);
        chk("ov_level3b", 32'(level2), 3);
        chk("ov_sticky", 32'(ovf2), 1);
        s_in = 18'd0;
        tick();
        chk("ov_order50", 32'(if2.dout), 50);
        chk("ov_level2", 32'(level2), 2);
        if2.dout_ready = 1'b0; s_in = 18'd320;
        tick();
        chk("pre_rst_level", 32'(level2), 3);
        chk("pre_rst_ovf", 32'(ovf2), 1);
        chk("pre_rst_head", 32'(if2.dout), 50);

        // Mid-stream reset flushes everything and restarts warm-up.
        reset = 1'b0; s_in = 18'd100; if2.dout_ready = 1'b1;
        tick();
        chk("mid_rst_level", 32'(level2), 0);
        chk("mid_rst_valid", 32'(if2.dout_valid), 0);
        chk("mid_rst_ovf", 32'(ovf2), 0);
        chk("mid_rst_dout", 32'(if2.dout), 0);
        reset = 1'b1;
        cyc   = -1;
        tick();
        for (int n = 0; n < 6; n++) begin
            chk("rewarm_valid", 32'(if2.dout_valid), 0);
            tick();
        end
        chk("rewarm_first_valid", 32'(if2.dout_valid), 1);
        chk("rewarm_first_dout", 32'(if2.dout), 25);

        // Ramp s_in = 4*k on D=1 and D=3.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        cyc   = -1;
        tick();
        for (int n = 0; n < 18; n++) begin
            s_in = 18'(4 * n);
            if (n >= 6) begin
                chk("d1_valid", 32'(if1.dout_valid), 1);
                chk("d1_dout", 32'(if1.dout), 32'(n - 1));
                if ((n - 6) % 3 == 0) begin
                    chk("d3_valid", 32'(if3.dout_valid), 1);
                    chk("d3_dout", 32'(if3.dout), 32'(n - 1));
                end else begin
                    chk("d3_idle", 32'(if3.dout_valid), 0);
                end
            end else begin
                chk("ramp_warm_d1", 32'(if1.dout_valid), 0);
            end
            tick();
        end
        chk("d1_no_ovf", 32'(ovf1), 0);
        chk("d3_no_ovf", 32'(ovf3), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_avg_decim.md
# fir_avg_decim

Downstream consumer of the 4-tap FIR moving-sum stage. It takes the free-running (w+2)-bit sum every clock and suppresses the pipeline-fill samples after reset. It converts each sum to a rounded w-bit average (sum/4), keeps one sample in every D, and buffers the results in a small FIFO. Results leave through a valid/ready interface toward the next consumer.

## Interface
- w, 16, input sample width; s_in is w+2 bits, dout is w bits
- D, 2, decimation factor, 1..256; D=1 keeps every sample
- DEPTH, 4, FIFO depth in entries, power of two, ≥2
- WARMUP, 5, number of cycles after reset release before s_in is valid
- clk  input  1  rising-edge clock, the only clock
- reset  input  1  synchronous, active-low; sampled on posedge clk, 0 = reset
- s_in  input  w+2  FIR sum, updated every cycle, unsigned
- dout  output  w  FIFO head: rounded average
- dout_valid  output  1  dout holds a valid entry
- dout_ready  input  1  consumer accepts dout this cycle
- level  output  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH
- ovf  output  1  sticky: a kept sample was dropped because the FIFO was full

## Operation
- Cycle numbering: cycle n is the cycle after the n-th rising edge with reset=1.
- Warm-up counter, states WARM → RUN:
  - WARM counts cycles 0..WARMUP-1; s_in is ignored.
  - At WARMUP it enters RUN and stays there until reset.
  - The counter saturates and does not wrap.
- In RUN, every cycle's s_in is an eligible sample, numbered i = 0, 1, 2, …
  - The decimation counter cycles 0..D-1 and keeps sample i when the counter is 0.
  - Counter wrap: D-1 → 0.
- Average: avg = (s_in + 2) >> 2, computed at w+2 bits.
  - The result always fits in w bits; the maximum is 2^w-1 and no saturation is needed.
  - The w-bit truncation is exact.
- FIFO behaviour:
  - Synchronous and first-word-fall-through; dout = mem[rd_ptr] whenever level > 0.
  - Pointers are $clog2(DEPTH)+1 bits with a wrap bit; full when the MSBs differ and the LSBs are equal.
- Push: a kept sample pushes avg.
- Pop: occurs when dout_valid && dout_ready.
- Boundary cases:
  - Full, no pop, kept sample arrives: the sample is dropped, ovf is set to 1, and FIFO contents are unchanged.
  - Full, pop and push in the same cycle: both occur, level stays DEPTH, no overflow.
  - Empty, push: no bypass; dout_valid rises the next cycle.
  - Empty, dout_ready=1: no effect.
  - dout_ready while dout_valid=0 is ignored.
  - dout and dout_valid must not depend combinationally on dout_ready.
- ovf is cleared only by reset.
- Reset mid-operation flushes the FIFO, clears all counters and ovf, and returns the block to WARM.

## Timing
- Reset values: dout_valid=0, level=0, ovf=0, dout=0. dout reads 0 whenever the FIFO is empty.
- Latency: a kept s_in in cycle n appears on dout in cycle n+1 if the FIFO was empty.
- First possible dout_valid is cycle WARMUP+1.
- level updates on the same edge as the push or pop; simultaneous push and pop leave it unchanged.
- ovf rises in the cycle after the dropping edge.
- Sustained throughput: one output per D cycles. With D=1 the consumer must hold dout_ready=1 continuously to avoid overflow.

## Structure
- Package fir_pkg holds:
  - typedef enum logic {WARM, RUN} warm_t
  - function round_div4 (sum width → w)
  - localparams for the default w and WARMUP, shared with the FIR stage
- Sub-module fir_sfifo (parameters WIDTH, DEPTH): FWFT memory, pointers, level and full/empty logic.
- The top level holds the warm-up FSM, the decimation counter, rounding and ovf.

## Test plan
Default parameters unless stated: w=16, D=2, DEPTH=4.
- Warm-up: release reset, s_in=100 constant, dout_ready=1.
  - dout_valid stays 0 through cycle 5; first output in cycle 6 with dout=25.
  - Thereafter valid every 2nd cycle.
- Rounding: s_in = 6, 5, 262140 in kept slots → dout = 2, 1, 65535.
  - Checks (6+2)>>2, (5+2)>>2, and max input.
- Backpressure and overflow: dout_ready=0 in RUN.
  - Level reaches 4 after 4 kept samples.
  - The 5th kept sample is dropped and ovf=1; the FIFO holds the first four values in order.
- Full with simultaneous pop/push: FIFO full and dout_ready=1 on the kept-sample cycle.
  - Level stays 4, ovf stays 0, the head advances to the second value.
- Reset mid-stream: assert reset for 1 cycle with level=3 and ovf=1.
  - Next cycle: level=0, dout_valid=0, ovf=0.
  - Warm-up restarts and the first output appears again at cycle 6.
- D=1 and D=3 with a ramp s_in=4·k.
  - D=1: dout = k for every k from the first valid sample.
  - D=3: dout follows every third k from the first valid sample.
